tpm_cmd_sequencer: RTL and testbench
====================================

# tpm_cmd_sequencer

Command initiator for the TPM management module: drives the `tpm_cc`/`cc_param` command inputs through the power-up sequence (TPM2_Startup, then TPM2_SelfTest) and, on request, TPM2_Shutdown. After each command it watches the module's 3-bit operational-state output until the expected state appears, a timeout expires, or failure mode is reported. It sits between board controls or a host controller and the management module, replacing the hand-set switch command path.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: wait-state timeout in clocks (20 ms at 50 MHz); legal range 2 to 2^24-1.
- `CMD_HOLD`, default 4: clocks each command is held valid; legal range 1 to 15.
- `CLOCK_50` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin the startup sequence; sampled in IDLE and SHUT_DONE.
- `startup_type` in 1: Startup parameter, 0 = CLEAR, 1 = STATE; captured on accepted `start`.
- `shutdown_req` in 1: begin shutdown; sampled in READY only.
- `clear_fail` in 1: leave FAIL to IDLE.
- `op_state` in 3: management-module state. 000 off, 001 init, 010 startup, 011 operational, 100 self-test, 101 failure, 110 shutdown.
- `tpm_cc` out 32: command code; 0x00000000 when no command is valid.
- `cc_param` out 16: command parameter; 0x0000 when no command is valid.
- `cmd_valid` out 1: command fields are valid.
- `busy` out 1: high in every state except IDLE, READY, SHUT_DONE and FAIL.
- `ready` out 1: high in READY.
- `fail` out 1: high in FAIL.
- `fail_code` out 2: 00 none, 01 timeout, 10 failure mode reported; holds its value until reset or `clear_fail`.
- `seq_state` out 4: current state encoding, for the LEDs and 7-segment display.

## Operation
- State encodings: IDLE 0, WAIT_INIT 1, ISS_STARTUP 2, WAIT_STARTUP 3, ISS_SELFTEST 4, WAIT_OPER 5, READY 6, ISS_SHUTDOWN 7, WAIT_SHUT 8, SHUT_DONE 9, FAIL 10. Other codes go to IDLE on the next clock.
- IDLE: on `start`, capture `startup_type` and go to WAIT_INIT.
- WAIT_INIT: on `op_state` = 001, go to ISS_STARTUP.
- ISS_STARTUP: `tpm_cc` = 0x00000144, `cc_param` = {15'b0, captured type}, then go to WAIT_STARTUP.
- WAIT_STARTUP: on `op_state` = 010 or 011, go to ISS_SELFTEST.
- ISS_SELFTEST: `tpm_cc` = 0x00000143, `cc_param` = 0x0001 (fullTest), then go to WAIT_OPER.
- WAIT_OPER: on `op_state` = 011, go to READY. Code 100 is tolerated and does not count as a match.
- READY: on `shutdown_req`, go to ISS_SHUTDOWN.
- ISS_SHUTDOWN: `tpm_cc` = 0x00000145, `cc_param` = {15'b0, captured type}, then go to WAIT_SHUT.
- WAIT_SHUT: on `op_state` = 110, go to SHUT_DONE.
- SHUT_DONE: on `start`, restart exactly as from IDLE.
- Timeout: a 24-bit counter clears on entry to each WAIT_* state and increments once per clock there. At count = TIMEOUT_CYCLES-1 with no match, go to FAIL with `fail_code` = 01.
- Failure priority: `op_state` = 101 in any WAIT_* state or READY forces FAIL with `fail_code` = 10. This outranks both a match and a timeout in the same cycle.
- FAIL: `clear_fail` goes to IDLE and sets `fail_code` to 00. `start` is ignored in FAIL.
- READY with `op_state` leaving 011 (other than 101): stay in READY and drop `ready`.
- `start` and `shutdown_req` asserted together: each is honoured only in its own sampling state; they never conflict.

## Timing
- All outputs are registered. Reset values: `tpm_cc` = 0, `cc_param` = 0, `cmd_valid` = 0, `busy` = 0, `ready` = 0, `fail` = 0, `fail_code` = 00, `seq_state` = 0.
- `start` high at edge N: `seq_state` = 1 and `busy` = 1 after edge N.
- A match sampled at edge N moves to the next state after edge N. An ISS_* state sets `cmd_valid` = 1 with the fields valid after the edge that enters it.
- Each ISS_* state lasts exactly CMD_HOLD clocks. `cmd_valid`, `tpm_cc` and `cc_param` return to 0 on the edge entering the following WAIT_* state. `op_state` is not checked during ISS_* states.
- Minimum `start`-to-`ready` latency: 2·CMD_HOLD + 4 clocks.
- Asserting `reset_n` low at any point, including mid-command, clears all outputs immediately, without waiting for a clock edge.

## Test plan
- Nominal startup: `start` with `startup_type` = 0; the model walks `op_state` 001, 010, 100, 011. Required: 0x00000144/0x0000 held 4 clocks, then 0x00000143/0x0001 held 4 clocks, then `ready` = 1, `seq_state` = 6.
- Shutdown: from READY pulse `shutdown_req`; model goes to 110. Required: 0x00000145/0x0000 held 4 clocks, then `seq_state` = 9. A further `start` with `startup_type` = 1 issues 0x00000144/0x0001.
- Timeout: TIMEOUT_CYCLES = 16; hold `op_state` at 000 after `start`. Required: `fail` = 1 and `fail_code` = 01 on the 16th clock in WAIT_INIT.
- Failure priority: in WAIT_OPER drive `op_state` = 101 in the same cycle the timeout expires. Required: `fail_code` = 10. Then `clear_fail` returns to `seq_state` = 0 with `fail_code` = 00.
- Reset mid-command: drop `reset_n` during the 2nd ISS_SELFTEST clock. Required: `cmd_valid` = 0, `tpm_cc` = 0 and `seq_state` = 0 before the next edge.
- Ignored inputs: `shutdown_req` in IDLE and `start` in READY or FAIL leave `seq_state` unchanged over 10 clocks.

Source files
------------

// File: rtl/tpm_cmd_sequencer.sv
// tpm_cmd_sequencer: issues TPM2_Startup/SelfTest/Shutdown and tracks the management module's op_state
module tpm_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CMD_HOLD = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        start,
  input  logic        startup_type,
  input  logic        shutdown_req,
  input  logic        clear_fail,
  input  logic [2:0]  op_state,
  output logic [31:0] tpm_cc,
  output logic [15:0] cc_param,
  output logic        cmd_valid,
  output logic        busy,
  output logic        ready,
  output logic        fail,
  output logic [1:0]  fail_code,
  output logic [3:0]  seq_state
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, WAIT_INIT = 4'd1, ISS_STARTUP = 4'd2, WAIT_STARTUP = 4'd3,
    ISS_SELFTEST = 4'd4, WAIT_OPER = 4'd5, READY = 4'd6, ISS_SHUTDOWN = 4'd7,
    WAIT_SHUT = 4'd8, SHUT_DONE = 4'd9, FAIL = 4'd10
  } state_t;
  state_t state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic type_q, type_d;
  logic [1:0] fail_code_q, fail_code_d;
  logic [31:0] tpm_cc_q, tpm_cc_d;
  logic [15:0] cc_param_q, cc_param_d;
  logic cmd_valid_q, cmd_valid_d, busy_q, busy_d, ready_q, ready_d, fail_q, fail_d;
  logic is_wait, is_iss, hold_done, tmo;
  // next state, shared wait/hold counter and registered output values
  always_comb begin
    state_d = state_q;
    type_d = type_q;
    fail_code_d = fail_code_q;
    is_wait = state_q inside {WAIT_INIT, WAIT_STARTUP, WAIT_OPER, WAIT_SHUT};
    is_iss = state_q inside {ISS_STARTUP, ISS_SELFTEST, ISS_SHUTDOWN};
    hold_done = cnt_q == 24'(CMD_HOLD - 1);
    tmo = cnt_q == 24'(TIMEOUT_CYCLES - 1);
    case (state_q)
      IDLE, SHUT_DONE: if (start) begin
        state_d = WAIT_INIT;
        type_d = startup_type;
      end
      WAIT_INIT:    state_d = (op_state == 3'b001) ? ISS_STARTUP : state_q;
      ISS_STARTUP:  state_d = hold_done ? WAIT_STARTUP : state_q;
      WAIT_STARTUP: state_d = (op_state inside {3'b010, 3'b011}) ? ISS_SELFTEST : state_q;
      ISS_SELFTEST: state_d = hold_done ? WAIT_OPER : state_q;
      WAIT_OPER:    state_d = (op_state == 3'b011) ? READY : state_q;
      READY:        state_d = shutdown_req ? ISS_SHUTDOWN : state_q;
      ISS_SHUTDOWN: state_d = hold_done ? WAIT_SHUT : state_q;
      WAIT_SHUT:    state_d = (op_state == 3'b110) ? SHUT_DONE : state_q;
      FAIL: if (clear_fail) begin
        state_d = IDLE;
        fail_code_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase
    if (is_wait && state_d == state_q && tmo) begin
      state_d = FAIL;
      fail_code_d = 2'b01;
    end
    if ((is_wait || state_q == READY) && op_state == 3'b101) begin
      state_d = FAIL;
      fail_code_d = 2'b10;
    end
    cnt_d = ((is_wait || is_iss) && state_d == state_q) ? cnt_q + 24'd1 : '0;
    cmd_valid_d = state_d inside {ISS_STARTUP, ISS_SELFTEST, ISS_SHUTDOWN};
    tpm_cc_d = (state_d == ISS_STARTUP) ? 32'h0000_0144 :
               (state_d == ISS_SELFTEST) ? 32'h0000_0143 :
               (state_d == ISS_SHUTDOWN) ? 32'h0000_0145 : '0;
    cc_param_d = (state_d == ISS_SELFTEST) ? 16'h0001 :
                 (state_d inside {ISS_STARTUP, ISS_SHUTDOWN}) ? {15'b0, type_d} : '0;
    busy_d = !(state_d inside {IDLE, READY, SHUT_DONE, FAIL});
    ready_d = state_d == READY && op_state == 3'b011;
    fail_d = state_d == FAIL;
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      type_q <= 1'b0;
      fail_code_q <= 2'b00;
      tpm_cc_q <= '0;
      cc_param_q <= '0;
      cmd_valid_q <= 1'b0;
      busy_q <= 1'b0;
      ready_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      type_q <= type_d;
      fail_code_q <= fail_code_d;
      tpm_cc_q <= tpm_cc_d;
      cc_param_q <= cc_param_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q <= busy_d;
      ready_q <= ready_d;
      fail_q <= fail_d;
    end
  end
  assign tpm_cc = tpm_cc_q;
  assign cc_param = cc_param_q;
  assign cmd_valid = cmd_valid_q;
  assign busy = busy_q;
  assign ready = ready_q;
  assign fail = fail_q;
  assign fail_code = fail_code_q;
  assign seq_state = state_q;
endmodule

// File: tb/tb_tpm_cmd_sequencer.sv
// tb_tpm_cmd_sequencer: directed stimulus with a command scoreboard and state checks
module tb_tpm_cmd_sequencer;
  logic CLOCK_50 = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, startup_type = 1'b0, shutdown_req = 1'b0, clear_fail = 1'b0;
  logic [2:0] op_state = 3'b000;
  logic [31:0] tpm_cc;
  logic [15:0] cc_param;
  logic cmd_valid, busy, ready, fail;
  logic [1:0] fail_code;
  logic [3:0] seq_state;
  int checks = 0, errors = 0;
  logic [47:0] exp_q[$];

  tpm_cmd_sequencer #(.TIMEOUT_CYCLES(16), .CMD_HOLD(4)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .startup_type(startup_type),
    .shutdown_req(shutdown_req), .clear_fail(clear_fail), .op_state(op_state),
    .tpm_cc(tpm_cc), .cc_param(cc_param), .cmd_valid(cmd_valid), .busy(busy),
    .ready(ready), .fail(fail), .fail_code(fail_code), .seq_state(seq_state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] cc, input logic [15:0] p, input int n);
    repeat (n) exp_q.push_back({cc, p});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      forever begin
        @(negedge CLOCK_50);
        if (reset_n) begin
          if (cmd_valid) begin
            if (exp_q.size() == 0) chk("unexpected_cmd", {tpm_cc, cc_param}, 48'h0);
            else chk("cmd", {tpm_cc, cc_param}, exp_q.pop_front());
          end else chk("idle_fields", {tpm_cc, cc_param}, 48'h0);
        end
      end
    join_none
    cyc(2);
    chk("rst_outputs", {tpm_cc, cc_param}, 48'h0);
    chk("rst_flags", {40'h0, cmd_valid, busy, ready, fail, fail_code}, 48'h0);
    chk("rst_seq", 48'(seq_state), 48'd0);
    reset_n = 1'b1;
    cyc(1);
    // nominal startup with CLEAR
    start = 1'b1;
    startup_type = 1'b0;
    push(32'h144, 16'h0000, 4);
    push(32'h143, 16'h0001, 4);
    cyc(1);
    start = 1'b0;
    chk("start_seq", 48'(seq_state), 48'd1);
    chk("start_busy", 48'(busy), 48'd1);
    op_state = 3'b001;
    cyc(1);
    chk("iss_startup", 48'(seq_state), 48'd2);
    op_state = 3'b010;
    cyc(4);
    chk("wait_startup", {44'(seq_state), 4'(cmd_valid)}, {44'd3, 4'd0});
    cyc(1);
    chk("iss_selftest", 48'(seq_state), 48'd4);
    op_state = 3'b100;
    cyc(4);
    chk("wait_oper", 48'(seq_state), 48'd5);
    cyc(2);
    chk("selftest_tolerated", 48'(seq_state), 48'd5);
    op_state = 3'b011;
    cyc(1);
    chk("ready_seq", 48'(seq_state), 48'd6);
    chk("ready_flags", {44'h0, busy, ready, fail, cmd_valid}, {44'h0, 4'b0100});
    op_state = 3'b010;
    cyc(1);
    chk("ready_drop", {44'(seq_state), 4'(ready)}, {44'd6, 4'd0});
    op_state = 3'b011;
    cyc(1);
    chk("ready_back", 48'(ready), 48'd1);
    start = 1'b1;
    cyc(10);
    start = 1'b0;
    chk("start_in_ready", 48'(seq_state), 48'd6);
    // shutdown, then restart with STATE
    push(32'h145, 16'h0000, 4);
    shutdown_req = 1'b1;
    cyc(1);
    shutdown_req = 1'b0;
    chk("iss_shutdown", 48'(seq_state), 48'd7);
    op_state = 3'b110;
    cyc(4);
    chk("wait_shut", 48'(seq_state), 48'd8);
    cyc(1);
    chk("shut_done", {44'(seq_state), 4'(busy)}, {44'd9, 4'd0});
    push(32'h144, 16'h0001, 4);
    push(32'h143, 16'h0001, 4);
    start = 1'b1;
    startup_type = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("restart_seq", 48'(seq_state), 48'd1);
    op_state = 3'b001;
    cyc(1);
    op_state = 3'b011;
    cyc(4);
    chk("restart_wait_startup", 48'(seq_state), 48'd3);
    cyc(1);
    cyc(4);
    chk("restart_wait_oper", 48'(seq_state), 48'd5);
    // failure outranks the simultaneous timeout
    op_state = 3'b100;
    cyc(15);
    chk("pre_timeout", {44'(seq_state), 4'(fail)}, {44'd5, 4'd0});
    op_state = 3'b101;
    cyc(1);
    chk("fail_prio", {40'(seq_state), 4'(fail), 4'(fail_code)}, {40'd10, 4'd1, 4'd2});
    op_state = 3'b000;
    start = 1'b1;
    cyc(10);
    start = 1'b0;
    chk("start_in_fail", {44'(seq_state), 4'(fail_code)}, {44'd10, 4'd2});
    clear_fail = 1'b1;
    cyc(1);
    clear_fail = 1'b0;
    chk("clear_fail", {40'(seq_state), 4'(fail), 4'(fail_code)}, 48'd0);
    shutdown_req = 1'b1;
    cyc(10);
    shutdown_req = 1'b0;
    chk("shutdown_in_idle", 48'(seq_state), 48'd0);
    // timeout in WAIT_INIT
    start = 1'b1;
    startup_type = 1'b0;
    cyc(1);
    start = 1'b0;
    cyc(15);
    chk("timeout_pre", {44'(seq_state), 4'(fail)}, {44'd1, 4'd0});
    cyc(1);
    chk("timeout", {40'(seq_state), 4'(fail), 4'(fail_code)}, {40'd10, 4'd1, 4'd1});
    clear_fail = 1'b1;
    cyc(1);
    clear_fail = 1'b0;
    // asynchronous reset during the second ISS_SELFTEST clock
    push(32'h144, 16'h0000, 4);
    push(32'h143, 16'h0001, 1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    op_state = 3'b001;
    cyc(1);
    op_state = 3'b011;
    cyc(4);
    cyc(1);
    chk("pre_reset_iss", {44'(seq_state), 4'(cmd_valid)}, {44'd4, 4'd1});
    cyc(1);
    reset_n = 1'b0;
    #2;
    chk("async_reset", {12'(seq_state), 4'(cmd_valid), tpm_cc}, 48'd0);
    cyc(2);
    reset_n = 1'b1;
    op_state = 3'b000;
    cyc(2);
    chk("queue_empty", 48'(exp_q.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
